// File: rtl/dff_bank_arb_pkg.sv
// Shared types, default sizes and the round-robin pointer helper for the
// DFF bank write-port arbiter.
package dff_bank_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int AW_DEF        = 3;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 8;

  // Wide enough for any NREQ in 2..8
  localparam int PTR_W = 3;

  // Next priority pointer after index idx, wrapping at n requesters
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx, input int n);
    logic [PTR_W-1:0] nxt;
    nxt = idx + 1'b1;
    if (int'(idx) + 1 >= n) nxt = '0;
    return nxt;
  endfunction

endpackage

// File: rtl/dff_bank_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr_i,
// wrapping modulo NREQ. gnt_o is one-hot (or zero when nothing requests).
module dff_bank_rr_pick
  import dff_bank_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  // Pick the requester with the smallest circular distance from ptr_i
  always_comb begin
    int   best_d;
    int   best_i;
    int   d;
    logic found;
    best_d = NREQ;
    best_i = 0;
    d      = 0;
    found  = 1'b0;
    gnt_o  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i]) begin
        d = (i + NREQ - int'(ptr_i)) % NREQ;
        if (d < best_d) begin
          best_d = d;
          best_i = i;
          found  = 1'b1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) gnt_o[i] = found && (best_i == i);
    idx_o = PTR_W'(best_i);
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin burst arbiter for the single write port of a DFF register bank.
// All outputs are registered. Optional burst-length limit with sticky error
// flag is enabled by defining DFF_ARB_TIMEOUT_EN.
module dff_bank_arbiter
  import dff_bank_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     c,
  input  logic                     rst_b,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic                     busy,
  output logic                     err_timeout
);

  arb_state_e       state_q;
  logic [NREQ-1:0]  gnt_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;
  logic             busy_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [PTR_W-1:0] pick_idx;

  logic             own_req, own_last;
  logic [AW-1:0]    own_addr;
  logic [DW-1:0]    own_data;
  logic             beat, to_hit, rel;

  dff_bank_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign ptr_d = ptr_inc(pick_idx, NREQ);

  // Select the owner's request lines using the one-hot grant as mux select
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_req  = own_req  | req[i];
        own_last = own_last | req_last[i];
        own_addr = own_addr | req_addr[i];
        own_data = own_data | req_data[i];
      end
    end
  end

  assign beat = (state_q == BURST) && own_req;
  assign rel  = beat && (own_last || to_hit);

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign to_hit      = beat && !own_last && (cnt_q == CW'(MAX_BURST - 1));
  assign err_timeout = err_q;

  // Beat counter (cleared while idle, so fresh on BURST entry) and sticky error
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) cnt_q <= '0;
      else if (beat)       cnt_q <= cnt_q + 1'b1;
      if (to_hit) err_q <= 1'b1;
    end
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Arbitration FSM with registered grant and bank write controls
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= 1'b0;
          if (|req) begin
            state_q <= BURST;
            gnt_q   <= pick_gnt;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
          end
        end
        BURST: begin
          wr_en_q <= beat;
          if (beat) begin
            wr_addr_q <= own_addr;
            wr_data_q <= own_data;
          end
          if (rel) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NREQ=4, AW=3, DW=8).
module tb_dff_bank_arbiter;

  logic             c = 1'b0;
  logic             rst_b = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0]       req_last = '0;
  logic [3:0][2:0]  req_addr = '0;
  logic [3:0][7:0]  req_data = '0;
  logic [3:0]       gnt;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             busy;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int  EXP_WRITES = 8;
  localparam logic EXP_ERR   = 1'b1;
`else
  localparam int  EXP_WRITES = 10;
  localparam logic EXP_ERR   = 1'b0;
`endif

  dff_bank_arbiter #(.NREQ(4), .AW(3), .DW(8), .MAX_BURST(8)) dut (
    .c(c), .rst_b(rst_b), .req(req), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 c = ~c;

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; req = '0; req_last = '0;
    repeat (2) step();
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111; req_last = '0; rst_b = 1'b0;
    #3;
    checks++; if ({gnt, wr_en, busy} !== 6'b0) begin errors++; $display("FAIL reset_async: gnt/wr_en/busy got %b expected 000000", {gnt, wr_en, busy}); end
    repeat (2) step();
    checks++; if ({gnt, wr_en, busy, wr_addr, wr_data, err_timeout} !== 18'b0) begin errors++; $display("FAIL reset_hold: outputs got %h expected 0", {gnt, wr_en, busy, wr_addr, wr_data, err_timeout}); end
    rst_b = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL reset_first_grant: gnt %b busy %b wr_en %b expected 0001 1 0", gnt, busy, wr_en); end
    req = 4'b0001; req_last = 4'b0001; req_addr[0] = 3'd2; req_data[0] = 8'h5A;
    step();
    checks++; if (gnt !== 4'b0000 || wr_en !== 1'b1 || wr_addr !== 3'd2 || wr_data !== 8'h5A) begin errors++; $display("FAIL reset_first_write: gnt %b wr_en %b addr %0d data %h expected 0000 1 2 5a", gnt, wr_en, wr_addr, wr_data); end
    req = '0; req_last = '0;
    step();
  endtask

  // ptr is 1 on entry; requester 2 wins
  task automatic test_single_burst();
    req = 4'b0100; req_last = '0; req_addr[2] = 3'd3; req_data[2] = 8'hA1;
    step();
    checks++; if (gnt !== 4'b0100 || busy !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL single_grant: gnt %b busy %b wr_en %b expected 0100 1 0", gnt, busy, wr_en); end
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 8'hA1 || gnt !== 4'b0100) begin errors++; $display("FAIL single_beat1: wr_en %b addr %0d data %h gnt %b expected 1 3 a1 0100", wr_en, wr_addr, wr_data, gnt); end
    req_addr[2] = 3'd4; req_data[2] = 8'hA2;
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd4 || wr_data !== 8'hA2 || gnt !== 4'b0100) begin errors++; $display("FAIL single_beat2: wr_en %b addr %0d data %h gnt %b expected 1 4 a2 0100", wr_en, wr_addr, wr_data, gnt); end
    req_addr[2] = 3'd5; req_data[2] = 8'hA3; req_last = 4'b0100;
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd5 || wr_data !== 8'hA3 || gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_last: wr_en %b addr %0d data %h gnt %b busy %b expected 1 5 a3 0000 0", wr_en, wr_addr, wr_data, gnt, busy); end
    req = '0; req_last = '0;
    step();
    checks++; if (wr_en !== 1'b0 || wr_addr !== 3'd5 || wr_data !== 8'hA3) begin errors++; $display("FAIL single_hold: wr_en %b addr %0d data %h expected 0 5 a3", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    logic [2:0] exp_addr [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1,
                                  3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 3'(i);
      req_data[i] = 8'h10 + 8'(i);
    end
    req = 4'b1111; req_last = 4'b1111;
    for (int s = 0; s < 10; s++) begin
      step();
      checks++; if (gnt !== exp_gnt[s] || wr_en !== (exp_gnt[s] == 4'b0000)) begin errors++; $display("FAIL fair_gnt step %0d: gnt %b wr_en %b expected %b %b", s, gnt, wr_en, exp_gnt[s], exp_gnt[s] == 4'b0000); end
      if (exp_gnt[s] == 4'b0000) begin
        checks++; if (wr_addr !== exp_addr[s]) begin errors++; $display("FAIL fair_addr step %0d: got %0d expected %0d", s, wr_addr, exp_addr[s]); end
      end
    end
    req = '0; req_last = '0;
    step();
  endtask

  // ptr is 1 on entry; requester 1 owns, then stalls while others request
  task automatic test_stall();
    req = 4'b0010; req_last = '0; req_addr[1] = 3'd1; req_data[1] = 8'h31;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b expected 0010", gnt); end
    step();
    checks++; if (wr_en !== 1'b1 || wr_data !== 8'h31) begin errors++; $display("FAIL stall_beat1: wr_en %b data %h expected 1 31", wr_en, wr_data); end
    req = 4'b1101; req_last = 4'b1101;
    for (int s = 0; s < 2; s++) begin
      step();
      checks++; if (wr_en !== 1'b0 || gnt !== 4'b0010 || busy !== 1'b1 || wr_addr !== 3'd1) begin errors++; $display("FAIL stall_cycle %0d: wr_en %b gnt %b busy %b addr %0d expected 0 0010 1 1", s, wr_en, gnt, busy, wr_addr); end
    end
    req = 4'b1111; req_last = 4'b0010; req_addr[1] = 3'd2; req_data[1] = 8'h32;
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd2 || wr_data !== 8'h32 || gnt !== 4'b0000) begin errors++; $display("FAIL stall_last: wr_en %b addr %0d data %h gnt %b expected 1 2 32 0000", wr_en, wr_addr, wr_data, gnt); end
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_next_grant: got %b expected 0100", gnt); end
    req_last = 4'b1111;
    step();
    req = '0; req_last = '0;
    step();
  endtask

  // ptr is 3 on entry; requester 3 owns a 4-beat burst cut by reset after beat 2
  task automatic test_reset_mid();
    req = 4'b1000; req_last = '0; req_addr[3] = 3'd6; req_data[3] = 8'h61;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b expected 1000", gnt); end
    step();
    req_addr[3] = 3'd7; req_data[3] = 8'h62;
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd7 || wr_data !== 8'h62) begin errors++; $display("FAIL rmid_beat2: wr_en %b addr %0d data %h expected 1 7 62", wr_en, wr_addr, wr_data); end
    rst_b = 1'b0;
    #2;
    checks++; if ({gnt, wr_en, busy, wr_addr, wr_data} !== 17'b0) begin errors++; $display("FAIL rmid_async_clear: outputs got %h expected 0", {gnt, wr_en, busy, wr_addr, wr_data}); end
    step();
    checks++; if (wr_en !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL rmid_no_write: wr_en %b gnt %b expected 0 0000", wr_en, gnt); end
    rst_b = 1'b1; req = 4'b1111;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_restart: got %b expected 0001", gnt); end
    req_last = 4'b1111;
    step();
    req = '0; req_last = '0;
    step();
  endtask

  task automatic test_timeout();
    int writes;
    do_reset();
    req = 4'b0001; req_last = '0;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_grant: got %b expected 0001", gnt); end
    writes = 0;
    for (int b = 0; b < 10; b++) begin
      req_addr[0] = 3'(b);
      req_data[0] = 8'h80 + 8'(b);
      step();
      if (wr_en) begin
        writes++;
        checks++; if (wr_data !== 8'h80 + 8'(b)) begin errors++; $display("FAIL to_data beat %0d: got %h expected %h", b, wr_data, 8'h80 + 8'(b)); end
      end
      if (gnt == 4'b0000) req = '0;
    end
    checks++; if (writes !== EXP_WRITES) begin errors++; $display("FAIL to_writes: got %0d expected %0d", writes, EXP_WRITES); end
    checks++; if (err_timeout !== EXP_ERR) begin errors++; $display("FAIL to_err: got %b expected %b", err_timeout, EXP_ERR); end
    if (gnt != 4'b0000) begin
      req_last = 4'b0001;
      step();
    end
    req = '0; req_last = '0;
    repeat (3) step();
    checks++; if (err_timeout !== EXP_ERR || gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky: err %b gnt %b busy %b expected %b 0000 0", err_timeout, gnt, busy, EXP_ERR); end
    rst_b = 1'b0;
    #2;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_reset: got %b expected 0", err_timeout); end
    step();
    rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
